ob_table_cnt_acc: RTL

// - Multi-beat table count accumulator: sums a packet of N-lane unsigned words

---
 rtl/ob_pkg.sv | 23 ++
 rtl/ob_table_cnt_csa.sv | 71 +++++++
 rtl/ob_table_cnt_acc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ob_pkg                                                                     |
// | Shared types for the ob_* datapath blocks: CSA compression styles and the  |
// | table count accumulator FSM state encoding.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ob_pkg;

   typedef enum logic [0:0] {
      CSA_3_2 = 1'b0,
      CSA_4_2 = 1'b1
   } csa_op_t;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      RES  = 4'b0010,
      ACC  = 4'b0100,
      OUT  = 4'b1000
   } ob_table_cnt_acc_st_t;

endpackage
`default_nettype wire

// File: rtl/ob_table_cnt_csa.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ob_table_cnt_csa                                                           |
// | Combinational carry-save reduction of N W-bit operands to a (s, c) pair.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ob_table_cnt_csa
   import ob_pkg::*;
#(
   parameter int      W  = 32,
   parameter int      N  = 10,
   parameter csa_op_t OP = CSA_3_2
)(
   input  logic [N-1:0][W-1:0] op_i,
   output logic [W-1:0]        s_o,
   output logic [W-1:0]        c_o
);

   function automatic logic [2*W-1:0] csa3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] d);
      logic [W-1:0] maj;
      maj = (a & b) | (a & d) | (b & d);
      return {a ^ b ^ d, maj[W-2:0], 1'b0};
   endfunction

   if (N == 1) begin : g_one
      assign s_o = op_i[0];
      assign c_o = '0;
   end else if (OP == CSA_4_2) begin : g_csa42
      logic [W-1:0]   s_v, c_v;
      logic [2*W-1:0] t_v, t2_v;
      // Each 4:2 step is two chained 3:2 stages consuming two operands.
      always_comb begin
         s_v  = op_i[0];
         c_v  = op_i[1];
         t_v  = '0;
         t2_v = '0;
         for (int k = 2; k + 1 < N; k += 2) begin
            t_v  = csa3(s_v, c_v, op_i[k]);
            t2_v = csa3(t_v[2*W-1:W], t_v[W-1:0], op_i[k+1]);
            s_v  = t2_v[2*W-1:W];
            c_v  = t2_v[W-1:0];
         end
         if ((N % 2) == 1) begin
            t_v = csa3(s_v, c_v, op_i[N-1]);
            s_v = t_v[2*W-1:W];
            c_v = t_v[W-1:0];
         end
      end
      assign s_o = s_v;
      assign c_o = c_v;
   end else begin : g_csa32
      logic [W-1:0]   s_v, c_v;
      logic [2*W-1:0] t_v;
      always_comb begin
         s_v = op_i[0];
         c_v = op_i[1];
         t_v = '0;
         for (int k = 2; k < N; k++) begin
            t_v = csa3(s_v, c_v, op_i[k]);
            s_v = t_v[2*W-1:W];
            c_v = t_v[W-1:0];
         end
      end
      assign s_o = s_v;
      assign c_o = c_v;
   end

endmodule
`default_nettype wire

// File: rtl/ob_table_cnt_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ob_table_cnt_acc                                                           |
// | Multi-beat table count accumulator: carry-save running total over N lanes  |
// | per beat, one carry-propagate add at end of packet.                        |
// | Option: OB_TABLE_CNT_ACC_SAT_EN saturates out_sum and flags out_ovf.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ob_table_cnt_acc
   import ob_pkg::*;
#(
   parameter int      W         = 32,
   parameter int      N         = 8,
   parameter int      MAX_BEATS = 16,
   parameter csa_op_t OP        = CSA_3_2,
   localparam int     BW        = $clog2(MAX_BEATS + 1)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [N-1:0][W-1:0] in_x,
   input  logic [N-1:0]       in_msk,
   input  logic               in_last,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [W-1:0]       out_sum,
   output logic [BW-1:0]      out_beats,
   output logic               out_ovf
);

   localparam int AW = W + $clog2(MAX_BEATS * N);
`ifdef OB_TABLE_CNT_ACC_SAT_EN
   localparam int SW = AW;
`else
   // Only the low W bits of the total are ever observed in the wrapping build.
   localparam int SW = W;
`endif

   ob_table_cnt_acc_st_t state_q, state_d;

   logic [AW-1:0]           s_q, c_q, s_w, c_w;
   logic [N+1:0][AW-1:0]    csa_in_w;
   logic [SW-1:0]           sum_q, sum_w;
   logic [BW-1:0]           beats_q, beats_inc_w, out_beats_q;
   logic                    accept_w, close_w;

   always_comb begin
      csa_in_w = '0;
      for (int i = 0; i < N; i++) begin
         csa_in_w[i] = in_msk[i] ? {{(AW-W){1'b0}}, in_x[i]} : '0;
      end
      csa_in_w[N]   = s_q;
      csa_in_w[N+1] = c_q;
   end

   ob_table_cnt_csa #(
      .W  (AW),
      .N  (N + 2),
      .OP (OP)
   ) u_csa (
      .op_i (csa_in_w),
      .s_o  (s_w),
      .c_o  (c_w)
   );

   assign in_rdy      = ~rst & ((state_q == IDLE) | (state_q == ACC));
   assign accept_w    = in_vld & in_rdy;
   assign beats_inc_w = beats_q + 1'b1;
   assign close_w     = in_last | (beats_inc_w == BW'(MAX_BEATS));
   assign sum_w       = s_q[SW-1:0] + c_q[SW-1:0];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, ACC: if (accept_w) state_d = close_w ? RES : ACC;
         RES:       state_d = OUT;
         OUT:       if (out_rdy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         s_q         <= '0;
         c_q         <= '0;
         beats_q     <= '0;
         sum_q       <= '0;
         out_beats_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_w) begin
            s_q     <= s_w;
            c_q     <= c_w;
            beats_q <= beats_inc_w;
         end
         if (state_q == RES) begin
            sum_q       <= sum_w;
            out_beats_q <= beats_q;
         end
         // Clear the running state on handoff so IDLE always starts from zero.
         if ((state_q == OUT) && out_rdy) begin
            s_q     <= '0;
            c_q     <= '0;
            beats_q <= '0;
         end
      end
   end

   assign out_vld   = (state_q == OUT);
   assign out_beats = out_beats_q;

`ifdef OB_TABLE_CNT_ACC_SAT_EN
   assign out_ovf = |sum_q[SW-1:W];
   assign out_sum = out_ovf ? '1 : sum_q[W-1:0];
`else
   assign out_ovf = 1'b0;
   assign out_sum = sum_q;
`endif

endmodule
`default_nettype wire
